// File: rtl/flow_mem_responder.sv
// flow_mem_responder: byte-addressed memory behind a fixed-latency ce/ready request port.
// Define FLOW_MEM_BACKDOOR_EN to add a word-wide backdoor write port (bd_we_i/bd_addr_i/bd_data_i).
module flow_mem_responder #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_width_i,
    input  logic [31:0] mem_data_i,
`ifdef FLOW_MEM_BACKDOOR_EN
    input  logic        bd_we_i,
    input  logic [31:0] bd_addr_i,
    input  logic [31:0] bd_data_i,
`endif
    output logic [31:0] mem_data_o,
    output logic        mem_ready_o,
    output logic        mem_err_o
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_width;
    logic [31:0] r_data;
    logic [7:0]  r_mem [DEPTH];
    logic        w_idle;
    logic        w_we;
    logic [31:0] w_addr;
    logic [3:0]  w_width;
    logic        w_ok;
    logic        w_to_resp;
    logic [31:0] w_rd;
    // In IDLE the live request is evaluated so that LATENCY=1 can respond off the accepting edge
    assign w_idle    = r_state == IDLE;
    assign w_we      = w_idle ? mem_we_i : r_we;
    assign w_addr    = w_idle ? mem_addr_i : r_addr;
    assign w_width   = w_idle ? mem_width_i : r_width;
    assign w_ok      = (w_width == 4'd1 || w_width == 4'd2 || w_width == 4'd4) &&
                       ({1'b0, w_addr} + {29'd0, w_width} <= 33'(DEPTH));
    assign w_to_resp = (w_idle && mem_ce_i && LATENCY == 1) || (r_state == BUSY && r_cnt == 4'd1);
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < 4; i++)
            if (4'(i) < w_width) w_rd[8*i +: 8] = r_mem[w_addr[AW-1:0] + AW'(i)];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            mem_ready_o <= 1'b0;
            mem_err_o   <= 1'b0;
            mem_data_o  <= '0;
        end else begin
            mem_ready_o <= w_to_resp;
            mem_err_o   <= w_to_resp && !w_ok;
            mem_data_o  <= (w_to_resp && w_ok && !w_we) ? w_rd : '0;
            case (r_state)
                IDLE: if (mem_ce_i) begin
                    r_we    <= mem_we_i;
                    r_addr  <= mem_addr_i;
                    r_width <= mem_width_i;
                    r_data  <= mem_data_i;
                    r_cnt   <= 4'(LATENCY - 1);
                    r_state <= (LATENCY == 1) ? RESP : BUSY;
                end
                BUSY: begin
                    r_cnt   <= r_cnt - 4'd1;
                    r_state <= (r_cnt == 4'd1) ? RESP : BUSY;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    // Backdoor is written first so a same-edge port write to the same byte wins
    always_ff @(posedge clk) begin
`ifdef FLOW_MEM_BACKDOOR_EN
        if (bd_we_i && bd_addr_i < 32'(DEPTH / 4))
            for (int i = 0; i < 4; i++) r_mem[{bd_addr_i[AW-3:0], 2'(i)}] <= bd_data_i[8*i +: 8];
`endif
        if (!rst && r_state == RESP && r_we && w_ok)
            for (int i = 0; i < 4; i++)
                if (4'(i) < r_width) r_mem[r_addr[AW-1:0] + AW'(i)] <= r_data[8*i +: 8];
    end
endmodule
